// File: rtl/weight_pingpong_buffer.sv
// Ping-pong weight store: TN banks x 2 pages x DEPTH words. The loader fills the shadow page
// bank-major while the PE array reads all banks of the active page. Build macro WBUF_OUT_REG_EN adds an output register.
module weight_pingpong_buffer #(
  parameter int TN         = 4,
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic [LEN_WIDTH-1:0]     cfg_len,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  output logic                     fill_done,
  input  logic                     swap,
  output logic                     act_valid,
  input  logic                     rd_en,
  input  logic [ADDR_WIDTH-1:0]    rd_addr,
  output logic [TN*DATA_WIDTH-1:0] rd_data,
  output logic                     rd_valid
);
  localparam int BANK_W     = (TN > 1) ? $clog2(TN) : 1;
  localparam int PHYS_W     = ADDR_WIDTH + 1;
  localparam int PHYS_WORDS = 1 << PHYS_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t                  state_r, state_next_s;
  logic [LEN_WIDTH-1:0]    len_r;
  logic [ADDR_WIDTH-1:0]   word_r;
  logic [BANK_W-1:0]       bank_r;
  logic                    act_page_r, act_valid_r, ld_ready_r, fill_done_r;
  logic                    start_ok_s, wr_en_s, swap_take_s;
  logic                    word_last_s, bank_last_s, fill_last_s;
  logic [DATA_WIDTH-1:0]   mem_r [TN][PHYS_WORDS];
  logic [TN*DATA_WIDTH-1:0] ram_rd_s, ram_q_r;
  logic                    ram_v_r;

  assign start_ok_s  = cfg_start && (cfg_len != {LEN_WIDTH{1'b0}}) && (cfg_len <= LEN_WIDTH'(DEPTH));
  assign word_last_s = (LEN_WIDTH'(word_r) == (len_r - LEN_WIDTH'(1)));
  assign bank_last_s = (bank_r == BANK_W'(TN - 1));
  assign fill_last_s = wr_en_s && word_last_s && bank_last_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_next_s;
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE:  if (start_ok_s)  state_next_s = S_FILL; else state_next_s = S_IDLE;
      S_FILL:  if (fill_last_s) state_next_s = S_FULL; else state_next_s = S_FILL;
      S_FULL:  if (swap)        state_next_s = S_IDLE; else state_next_s = S_FULL;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Output decode: write strobe in FILL, swap acceptance only in FULL
  always_comb begin
    wr_en_s     = 1'b0;
    swap_take_s = 1'b0;
    case (state_r)
      S_FILL:  wr_en_s     = ld_valid && ld_ready_r;
      S_FULL:  swap_take_s = swap;
      default: begin
        wr_en_s     = 1'b0;
        swap_take_s = 1'b0;
      end
    endcase
  end

  // Fill counters, page select and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r       <= {LEN_WIDTH{1'b0}};
      word_r      <= {ADDR_WIDTH{1'b0}};
      bank_r      <= {BANK_W{1'b0}};
      act_page_r  <= 1'b0;
      act_valid_r <= 1'b0;
      ld_ready_r  <= 1'b0;
      fill_done_r <= 1'b0;
    end else begin
      ld_ready_r  <= (state_next_s == S_FILL);
      fill_done_r <= fill_last_s;
      if (state_r == S_IDLE && start_ok_s) begin
        len_r  <= cfg_len;
        word_r <= {ADDR_WIDTH{1'b0}};
        bank_r <= {BANK_W{1'b0}};
      end else if (wr_en_s) begin
        if (word_last_s) begin
          word_r <= {ADDR_WIDTH{1'b0}};
          bank_r <= bank_r + BANK_W'(1);
        end else begin
          word_r <= word_r + ADDR_WIDTH'(1);
        end
      end
      if (swap_take_s) begin
        act_page_r  <= ~act_page_r;
        act_valid_r <= 1'b1;
      end
    end
  end

  // Shadow-page write port; RAM contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[bank_r][{~act_page_r, word_r}] <= ld_data;
  end

  // Active-page read of all banks at one word index
  always_comb begin
    ram_rd_s = {(TN*DATA_WIDTH){1'b0}};
    for (int b = 0; b < TN; b++) begin
      ram_rd_s[b*DATA_WIDTH +: DATA_WIDTH] = mem_r[b][{act_page_r, rd_addr}];
    end
  end

  // Read data register; holds its last value between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_q_r <= {(TN*DATA_WIDTH){1'b0}};
      ram_v_r <= 1'b0;
    end else begin
      ram_v_r <= rd_en;
      if (rd_en) ram_q_r <= ram_rd_s;
    end
  end

`ifdef WBUF_OUT_REG_EN
  logic [TN*DATA_WIDTH-1:0] out_q_r;
  logic                     out_v_r;

  // Extra output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q_r <= {(TN*DATA_WIDTH){1'b0}};
      out_v_r <= 1'b0;
    end else begin
      out_v_r <= ram_v_r;
      if (ram_v_r) out_q_r <= ram_q_r;
    end
  end

  assign rd_data  = out_q_r;
  assign rd_valid = out_v_r;
`else
  assign rd_data  = ram_q_r;
  assign rd_valid = ram_v_r;
`endif

  assign ld_ready  = ld_ready_r;
  assign fill_done = fill_done_r;
  assign act_valid = act_valid_r;

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// Self-checking bench for weight_pingpong_buffer (TN=4, DEPTH=16, DATA_WIDTH=64) with a
// transaction-level model of pages, fills, swaps and the read pipeline.
module tb_weight_pingpong_buffer;
  localparam int TN = 4, DEPTH = 16, DW = 64, AW = 4, LW = 5;
`ifdef WBUF_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst, cfg_start, ld_valid, swap, rd_en;
  logic [LW-1:0] cfg_len;
  logic [DW-1:0] ld_data;
  logic [AW-1:0] rd_addr;
  logic ld_ready, fill_done, act_valid, rd_valid;
  logic [TN*DW-1:0] rd_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  weight_pingpong_buffer #(.TN(TN), .DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .fill_done(fill_done),
    .swap(swap), .act_valid(act_valid), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  // Reference model: physical RAM image plus fill/page bookkeeping
  logic [DW-1:0] m_mem [2][TN][DEPTH];
  bit m_filling, m_full, m_page, m_act_valid;
  int m_len, m_count;
  bit pv [LAT];
  logic [TN*DW-1:0] pd [LAT];
  logic [TN*DW-1:0] exp_rd_data;
  bit exp_rd_valid;

  task automatic m_reset();
    m_filling = 0; m_full = 0; m_page = 0; m_act_valid = 0;
    m_len = 0; m_count = 0;
    for (int i = 0; i < LAT; i++) begin pv[i] = 0; pd[i] = '0; end
    exp_rd_data = '0; exp_rd_valid = 0;
  endtask

  // One clock edge: update the model from the inputs sampled at the edge
  task automatic tick();
    bit acc;
    logic [TN*DW-1:0] rword;
    @(posedge clk);
    acc = m_filling && ld_valid;
    rword = '0;
    for (int b = 0; b < TN; b++) rword[b*DW +: DW] = m_mem[m_page][b][rd_addr];
    for (int i = LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
    pv[0] = rd_en; pd[0] = rword;
    if (pv[LAT-1]) exp_rd_data = pd[LAT-1];
    exp_rd_valid = pv[LAT-1];
    if (acc) begin
      m_mem[!m_page][m_count / m_len][m_count % m_len] = ld_data;
      m_count++;
      if (m_count == TN * m_len) begin m_filling = 0; m_full = 1; end
    end else if (!m_filling && !m_full && cfg_start && cfg_len >= 1 && cfg_len <= DEPTH) begin
      m_filling = 1; m_count = 0; m_len = int'(cfg_len);
    end else if (m_full && swap) begin
      m_full = 0; m_page = !m_page; m_act_valid = 1;
    end
    #1;
  endtask

  task automatic start_fill(input int len);
    cfg_start = 1'b1; cfg_len = LW'(len);
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  // Loader stimulus. vmode: 0 always valid, 1 toggle 1010.., 2 random. dmode: 0 fill index, 1 random.
  task automatic feed(input int max_acc, input int cycles, input int vmode, input int dmode,
                      output int acc, output int dones);
    bit vld, r;
    acc = 0; dones = 0;
    for (int c = 0; c < cycles && acc < max_acc; c++) begin
      vld = (vmode == 0) ? 1'b1 : (vmode == 1) ? (c % 2 == 0) : ($urandom_range(0, 3) != 0);
      ld_valid = vld;
      ld_data = (dmode == 0) ? DW'(m_count) : {$urandom, $urandom};
      r = ld_ready;
      tick();
      if (r && vld) acc++;
      if (fill_done) dones++;
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_start = 0; cfg_len = '0; ld_valid = 0; ld_data = '0; swap = 0; rd_en = 0; rd_addr = '0;
    for (int p = 0; p < 2; p++) for (int b = 0; b < TN; b++) for (int w = 0; w < DEPTH; w++) m_mem[p][b][w] = '0;
    m_reset();
    #12;
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
    total++; if (fill_done !== 1'b0) begin bad++; $display("FAIL reset_fill_done: got %b want 0", fill_done); end
    total++; if (act_valid !== 1'b0) begin bad++; $display("FAIL reset_act_valid: got %b want 0", act_valid); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_swap_ignored();
    int acc, dones;
    do_swap();
    tick();
    total++; if (act_valid !== 1'b0) begin bad++; $display("FAIL idle_swap_act_valid: got %b want 0", act_valid); end
    start_fill(16);
    feed(10, 100, 2, 1, acc, dones);
    do_swap();
    total++; if (act_valid !== 1'b0) begin bad++; $display("FAIL fill_swap_act_valid: got %b want 0", act_valid); end
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL fill_swap_ld_ready: got %b want 1", ld_ready); end
    start_fill(3);
    feed(54, 400, 0, 1, acc, dones);
    total++; if (acc !== 54) begin bad++; $display("FAIL fill_restart_ignored_acc: got %0d want 54", acc); end
    total++; if (dones !== 1) begin bad++; $display("FAIL fill_restart_ignored_done: got %0d want 1", dones); end
    do_swap();
    total++; if (act_valid !== 1'b1) begin bad++; $display("FAIL swap_act_valid: got %b want 1", act_valid); end
    rd_en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      tick();
      if (c >= LAT - 1) begin
        total++; if (rd_data !== exp_rd_data || rd_valid !== 1'b1) begin bad++;
          $display("FAIL swap_ignored_read: got %h/%b want %h/1", rd_data, rd_valid, exp_rd_data); end
      end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_fill_basic();
    int acc, dones;
    logic [TN*DW-1:0] want;
    want = {64'd51, 64'd35, 64'd19, 64'd3};
    start_fill(16);
    feed(64, 300, 0, 0, acc, dones);
    total++; if (acc !== 64) begin bad++; $display("FAIL fill64_acc: got %0d want 64", acc); end
    total++; if (fill_done !== 1'b1) begin bad++; $display("FAIL fill64_done_pulse: got %b want 1", fill_done); end
    total++; if (dones !== 1) begin bad++; $display("FAIL fill64_done_count: got %0d want 1", dones); end
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL fill64_ld_ready: got %b want 0", ld_ready); end
    tick();
    total++; if (fill_done !== 1'b0) begin bad++; $display("FAIL fill64_done_clear: got %b want 0", fill_done); end
    do_swap();
    rd_en = 1'b1; rd_addr = AW'(3);
    tick();
    rd_en = 1'b0;
    repeat (LAT - 1) tick();
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL read3_valid: got %b want 1", rd_valid); end
    total++; if (rd_data !== want) begin bad++; $display("FAIL read3_data: got %h want %h", rd_data, want); end
    tick();
    total++; if (rd_valid !== 1'b0 || rd_data !== want) begin bad++;
      $display("FAIL read_hold: got %h/%b want %h/0", rd_data, rd_valid, want); end
  endtask

  task automatic test_pingpong();
    bit swapped;
    int post;
    swapped = 0; post = 0;
    rd_en = 1'b1;
    cfg_start = 1'b1; cfg_len = LW'(16);
    for (int c = 0; c < 400 && post < 8; c++) begin
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      ld_valid = m_filling && ($urandom_range(0, 3) != 0);
      if (m_filling) ld_data = m_mem[m_page][m_count / m_len][m_count % m_len] + 64'd100;
      swap = m_full && !swapped;
      if (swap) swapped = 1;
      tick();
      cfg_start = 1'b0;
      if (swapped) post++;
      if (c >= LAT) begin
        total++; if (rd_valid !== 1'b1 || rd_data !== exp_rd_data) begin bad++;
          $display("FAIL pingpong_read c=%0d: got %h/%b want %h/1", c, rd_data, rd_valid, exp_rd_data); end
      end
    end
    total++; if (post !== 8) begin bad++; $display("FAIL pingpong_timeout: got post=%0d want 8", post); end
    rd_en = 1'b0; swap = 1'b0; ld_valid = 1'b0;
    tick();
  endtask

  task automatic test_partial_len();
    int acc, dones;
    logic [TN*DW-1:0] want;
    want = {64'd19, 64'd14, 64'd9, 64'd4};
    start_fill(5);
    feed(1000, 60, 1, 0, acc, dones);
    total++; if (acc !== 20) begin bad++; $display("FAIL len5_acc: got %0d want 20", acc); end
    total++; if (dones !== 1) begin bad++; $display("FAIL len5_done_count: got %0d want 1", dones); end
    do_swap();
    rd_en = 1'b1; rd_addr = AW'(4);
    tick();
    rd_en = 1'b0;
    repeat (LAT - 1) tick();
    total++; if (rd_data !== want) begin bad++; $display("FAIL len5_read4: got %h want %h", rd_data, want); end
    rd_en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      rd_addr = AW'($urandom_range(0, 4));
      tick();
      if (c >= LAT - 1) begin
        total++; if (rd_data !== exp_rd_data) begin bad++;
          $display("FAIL len5_rand_read: got %h want %h", rd_data, exp_rd_data); end
      end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_midfill();
    int acc, dones;
    start_fill(16);
    rd_en = 1'b1; rd_addr = AW'(0);
    feed(10, 100, 0, 1, acc, dones);
    #2 rst = 1'b1;
    #1;
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_ld_ready: got %b want 0", ld_ready); end
    total++; if (act_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_act_valid: got %b want 0", act_valid); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_rd_valid: got %b want 0", rd_valid); end
    m_reset();
    rd_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    start_fill(16);
    feed(64, 400, 2, 1, acc, dones);
    total++; if (acc !== 64 || dones !== 1) begin bad++;
      $display("FAIL refill_after_rst: got acc=%0d done=%0d want 64/1", acc, dones); end
    do_swap();
    total++; if (act_valid !== 1'b1) begin bad++; $display("FAIL refill_act_valid: got %b want 1", act_valid); end
    rd_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      tick();
      if (c >= LAT - 1) begin
        total++; if (rd_data !== exp_rd_data) begin bad++;
          $display("FAIL refill_read: got %h want %h", rd_data, exp_rd_data); end
      end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_bad_len_and_swap_start();
    int acc, dones;
    start_fill(0);
    tick();
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL len0_ld_ready: got %b want 0", ld_ready); end
    start_fill(17);
    tick();
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL len17_ld_ready: got %b want 0", ld_ready); end
    start_fill(2);
    feed(8, 100, 0, 1, acc, dones);
    total++; if (acc !== 8) begin bad++; $display("FAIL len2_acc: got %0d want 8", acc); end
    swap = 1'b1; cfg_start = 1'b1; cfg_len = LW'(4);
    tick();
    swap = 1'b0; cfg_start = 1'b0;
    total++; if (act_valid !== 1'b1 || ld_ready !== 1'b0) begin bad++;
      $display("FAIL swap_start_same: got act_valid=%b ld_ready=%b want 1/0", act_valid, ld_ready); end
    tick();
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL swap_start_no_fill: got %b want 0", ld_ready); end
    start_fill(1);
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL idle_after_swap: got %b want 1", ld_ready); end
    feed(4, 50, 2, 1, acc, dones);
    do_swap();
    rd_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      tick();
      if (c >= LAT - 1) begin
        total++; if (rd_data !== exp_rd_data) begin bad++;
          $display("FAIL len1_stale_read: got %h want %h", rd_data, exp_rd_data); end
      end
    end
    rd_en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_swap_ignored();
    test_fill_basic();
    test_pingpong();
    test_partial_len();
    test_reset_midfill();
    test_bad_len_and_swap_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
